// File: rtl/lif_pkg.sv
// Shared constants, FSM encodings and width helpers for the time-multiplexed LIF scheduler.
package lif_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LIF_V_0    = 14;
  localparam int LIF_V_REST = 6;
  localparam int LIF_V_LEAK = 1;
  localparam int LIF_K_SYN  = 1;

  // Voltage register width: just enough to hold the threshold.
  function automatic int vw_f(input int v0);
    return $clog2(v0 + 1);
  endfunction

  // Width of the weighted synaptic sum before gain.
  function automatic int aw_f(input int ww, input int s);
    return ww + $clog2(s) + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int iw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron leaky integrate-and-fire update.
module lif_update import lif_pkg::*; #(
  parameter int S      = 4,
  parameter int WW     = 4,
  parameter int V_0    = LIF_V_0,
  parameter int V_REST = LIF_V_REST,
  parameter int V_LEAK = LIF_V_LEAK,
  parameter int K_SYN  = LIF_K_SYN
) (
  input  logic [vw_f(V_0)-1:0] v,
  input  logic [S-1:0][WW-1:0] w_row,
  input  logic [S-1:0]         spk,
  input  logic                 frc,
  output logic [vw_f(V_0)-1:0] v_next,
  output logic                 spike
);
  localparam int VW = vw_f(V_0);
  // Headroom so gain, sum and leak never wrap before the compare.
  localparam int XW = aw_f(WW, S) + VW + 2;
  localparam logic signed [XW-1:0] THR  = XW'(V_0);
  localparam logic signed [XW-1:0] GAIN = XW'(K_SYN);
  localparam logic signed [XW-1:0] LEAK = XW'(V_LEAK);

  logic signed [XW-1:0] sum, vs;
  logic                 fire;

  always_comb begin
    sum = '0;
    for (int j = 0; j < S; j++)
      if (spk[j]) sum = sum + $signed(XW'(w_row[j]));
    vs     = $signed(XW'(v)) + GAIN * sum - LEAK;
    fire   = (vs >= THR);
    // Below threshold vs fits in VW bits, so truncation is exact.
    v_next = fire ? VW'(V_REST) : ((vs < 0) ? '0 : VW'(vs));
    spike  = fire | frc;
  end

endmodule

// File: rtl/lif_tm_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath walks N neurons per timestep.
module lif_tm_scheduler import lif_pkg::*; #(
  parameter int N      = 8,
  parameter int S      = 4,
  parameter int WW     = 4,
  parameter int V_0    = LIF_V_0,
  parameter int V_REST = LIF_V_REST,
  parameter int V_LEAK = LIF_V_LEAK,
  parameter int K_SYN  = LIF_K_SYN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic [S-1:0]           in_spikes,
  input  logic [N-1:0]           force_mask,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           out_spikes,
  input  logic                   cfg_we,
  input  logic [iw_f(N)-1:0]     cfg_nrn,
  input  logic [iw_f(S)-1:0]     cfg_syn,
  input  logic [WW-1:0]          cfg_w,
  output logic                   cfg_ready,
  input  logic [iw_f(N)-1:0]     v_rd_addr,
  output logic [vw_f(V_0)-1:0]   v_rd_data
);
  localparam int VW = vw_f(V_0);
  localparam int IW = iw_f(N);
  localparam int SW = iw_f(S);
  localparam logic [IW:0]   N_L  = (IW+1)'(N);
  localparam logic [SW:0]   S_L  = (SW+1)'(S);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [1:0]                  state;
  logic [IW-1:0]               idx;
  logic [S-1:0]                spk_q;
  logic [N-1:0]                frc_q, nxt_spk, spk_vec;
  logic [N-1:0][VW-1:0]        v_mem;
  logic [N-1:0][S-1:0][WW-1:0] w_mem;
  logic [VW-1:0]               v_new;
  logic                        spike;

  assign busy      = (state != ST_IDLE);
  assign cfg_ready = ~busy;
  assign v_rd_data = ({1'b0, v_rd_addr} < N_L) ? v_mem[v_rd_addr] : '0;

  lif_update #(
    .S(S), .WW(WW), .V_0(V_0), .V_REST(V_REST), .V_LEAK(V_LEAK), .K_SYN(K_SYN)
  ) u_upd (
    .v      (v_mem[idx]),
    .w_row  (w_mem[idx]),
    .spk    (spk_q),
    .frc    (frc_q[idx]),
    .v_next (v_new),
    .spike  (spike)
  );

  // Spike vector including the neuron being processed this cycle.
  always_comb begin
    spk_vec      = nxt_spk;
    spk_vec[idx] = spike;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      spk_q      <= '0;
      frc_q      <= '0;
      nxt_spk    <= '0;
      out_spikes <= '0;
      done       <= 1'b0;
      w_mem      <= '0;
      for (int i = 0; i < N; i++) v_mem[i] <= VW'(V_REST);
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Weight write lands at the same edge that accepts step, so the run sees it.
          if (cfg_we && ({1'b0, cfg_nrn} < N_L) && ({1'b0, cfg_syn} < S_L))
            w_mem[cfg_nrn][cfg_syn] <= cfg_w;
          if (step) begin
            state <= ST_RUN;
            spk_q <= in_spikes;
            frc_q <= force_mask;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          v_mem[idx] <= v_new;
          nxt_spk    <= spk_vec;
          if (idx == LAST) begin
            // Publish at the RUN->DONE edge so out_spikes is valid with done.
            state      <= ST_DONE;
            idx        <= '0;
            out_spikes <= spk_vec;
            done       <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_tm_scheduler.sv
// Randomized + directed bench for lif_tm_scheduler (N=4, S=2) against an integer reference model.
module tb_lif_tm_scheduler;
  localparam int N = 4;
  localparam int S = 2;
  localparam int WW = 4;

  logic         clk = 1'b0;
  logic         reset, step, cfg_we;
  logic [S-1:0] in_spikes;
  logic [N-1:0] force_mask, out_spikes;
  logic         busy, done, cfg_ready;
  logic [1:0]   cfg_nrn, v_rd_addr;
  logic [0:0]   cfg_syn;
  logic [3:0]   cfg_w, v_rd_data;

  int n_cmp = 0;
  int n_fail = 0;

  int mv[N];
  int mw[N][S];
  logic [N-1:0] mout;

  always #5 clk = ~clk;

  lif_tm_scheduler #(.N(N), .S(S), .WW(WW)) dut (
    .clk(clk), .reset(reset), .step(step), .in_spikes(in_spikes),
    .force_mask(force_mask), .busy(busy), .done(done), .out_spikes(out_spikes),
    .cfg_we(cfg_we), .cfg_nrn(cfg_nrn), .cfg_syn(cfg_syn), .cfg_w(cfg_w),
    .cfg_ready(cfg_ready), .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 6;
      for (int j = 0; j < S; j++) mw[i][j] = 0;
    end
    mout = '0;
  endtask

  task automatic model_step(input logic [S-1:0] spk, input logic [N-1:0] msk);
    for (int i = 0; i < N; i++) begin
      int sum, vs;
      bit fire;
      sum = 0;
      for (int j = 0; j < S; j++) if (spk[j]) sum += mw[i][j];
      vs = mv[i] + 1 * sum - 1;
      fire = (vs >= 14);
      mv[i] = fire ? 6 : ((vs < 0) ? 0 : vs);
      mout[i] = fire | msk[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_v(input string tag);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      v_rd_addr = 2'(i);
      #1;
      chk($sformatf("%s_v%0d", tag, i), 32'(v_rd_data), 32'(mv[i]));
    end
  endtask

  task automatic cfg_write(input int n, input int s, input int w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_nrn = 2'(n); cfg_syn = 1'(s); cfg_w = 4'(w);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mw[n][s] = w;
  endtask

  // One timestep, optionally with a weight write in the accepting cycle.
  task automatic run_step(input string tag, input logic [S-1:0] spk, input logic [N-1:0] msk,
                          input bit wr, input int wn, input int ws, input int wv);
    int k;
    bit seen;
    @(negedge clk);
    step = 1'b1; in_spikes = spk; force_mask = msk;
    if (wr) begin
      cfg_we = 1'b1; cfg_nrn = 2'(wn); cfg_syn = 1'(ws); cfg_w = 4'(wv);
      mw[wn][ws] = wv;
    end
    @(posedge clk); #1;
    step = 1'b0; cfg_we = 1'b0;
    model_step(spk, msk);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    k = 1; seen = 0;
    while (!seen && k <= N + 4) begin
      if (done) seen = 1;
      else begin @(posedge clk); #1; k++; end
    end
    chk({tag, "_lat"}, 32'(k), 32'(N + 1));
    chk({tag, "_out"}, 32'(out_spikes), 32'(mout));
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    check_v(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    reset = 1'b1; step = 1'b0; cfg_we = 1'b0; in_spikes = '0; force_mask = '0;
    cfg_nrn = '0; cfg_syn = '0; cfg_w = '0; v_rd_addr = '0;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out_spikes), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_v("rst");

    // Idle timestep: everything leaks to 5
    run_step("idle", 2'b00, 4'b0000, 0, 0, 0, 0);
    chk("idle_v_const", 32'(mv[0]), 32'd5);

    // Exactly-at-threshold fire
    do_reset();
    cfg_write(0, 0, 9);
    run_step("fire", 2'b01, 4'b0000, 0, 0, 0, 0);
    chk("fire_out_const", 32'(out_spikes), 32'b0001);

    // Leak clamp at zero
    do_reset();
    for (int s = 0; s < 8; s++) run_step($sformatf("leak%0d", s), 2'b00, 4'b0000, 0, 0, 0, 0);
    v_rd_addr = 2'd2; #1;
    chk("leak_floor", 32'(v_rd_data), 32'd0);

    // Forced spike leaves voltage alone
    do_reset();
    run_step("frc", 2'b00, 4'b1000, 0, 0, 0, 0);
    chk("frc_out_const", 32'(out_spikes), 32'b1000);
    run_step("frc_clr", 2'b00, 4'b0000, 0, 0, 0, 0);

    // step and cfg_we during busy are dropped
    do_reset();
    @(negedge clk);
    step = 1'b1; in_spikes = 2'b01; force_mask = '0;
    @(posedge clk); #1;
    step = 1'b0;
    model_step(2'b01, 4'b0000);
    dcnt = 0;
    for (int c = 1; c <= 2 * N + 6; c++) begin
      if (c == 2) begin
        step = 1'b1; cfg_we = 1'b1; cfg_nrn = 2'd1; cfg_syn = 1'd0; cfg_w = 4'd15;
      end else begin
        step = 1'b0; cfg_we = 1'b0;
      end
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("busy_ign_done_cnt", 32'(dcnt), 32'd1);
    chk("busy_ign_idle", 32'(busy), 32'd0);
    run_step("busy_ign_w", 2'b01, 4'b0000, 0, 0, 0, 0);

    // Reset mid-run aborts without a done pulse
    do_reset();
    cfg_write(2, 1, 13);
    @(negedge clk);
    step = 1'b1; in_spikes = 2'b11; force_mask = 4'b1111;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("abort_busy", 32'(busy), 32'd0);
    dcnt = 0;
    for (int c = 0; c < N + 3; c++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    chk("abort_out", 32'(out_spikes), 32'd0);
    check_v("abort");
    run_step("abort_w", 2'b11, 4'b0000, 0, 0, 0, 0);

    // Randomized timesteps with random weight programming
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(0, N - 1), $urandom_range(0, S - 1), $urandom_range(0, 15));
      run_step($sformatf("rnd%0d", it), 2'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0), $urandom_range(0, N - 1), $urandom_range(0, S - 1),
               $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_tm_scheduler.md
Name: lif_tm_scheduler

Overview:
- Time-multiplexed controller sharing one leaky integrate-and-fire update datapath among N logical neurons.
- Each `step` pulse runs one network timestep:
  - captures the presynaptic spike vector and the force mask;
  - walks neuron indices 0..N-1, one neuron per cycle;
  - publishes the new output spike vector with a one-cycle `done` pulse.
- Holds per-neuron membrane voltages and a per-neuron/per-synapse weight table. Sits between the spike-event fabric and downstream spike consumers.

Parameters:
- N, 8, number of logical neurons (≥2)
- S, 4, synapses per neuron (≥1)
- WW, 4, synaptic weight width (unsigned)
- V_0, 14, firing threshold
- V_REST, 6, post-spike and reset voltage
- V_LEAK, 1, per-timestep leak
- K_SYN, 1, synaptic gain

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- step  in  1  start-timestep request; sampled only in IDLE
- in_spikes  in  S  presynaptic spikes, shared by all neurons; captured on accepted step
- force_mask  in  N  per-neuron forced spike; captured on accepted step
- busy  out  1  timestep in progress
- done  out  1  one-cycle pulse; out_spikes valid
- out_spikes  out  N  spike vector of last completed timestep
- cfg_we  in  1  weight write strobe
- cfg_nrn  in  $clog2(N)  weight write neuron index
- cfg_syn  in  $clog2(S)  weight write synapse index
- cfg_w  in  WW  weight value
- cfg_ready  out  1  equals !busy; cfg_we ignored when low
- v_rd_addr  in  $clog2(N)  debug voltage read index
- v_rd_data  out  VW  combinational read of stored voltage

Behaviour:
- Widths:
  - VW = $clog2(V_0+1).
  - Sum width AW = WW + $clog2(S) + 1.
  - Update arithmetic is signed at AW+VW+2 bits; no wrap is permitted.
- Reset:
  - all V[i] = V_REST; all weights = 0;
  - out_spikes = 0, done = 0, busy = 0; state IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE, step=1 → RUN. Latch in_spikes→spk_q and force_mask→frc_q; idx = 0.
  - RUN → process neuron idx each cycle:
    - sum = Σ_j (spk_q[j] ? W[idx][j] : 0)
    - Vs = V[idx] + K_SYN*sum − V_LEAK
    - fire = (Vs ≥ V_0)
    - V[idx] ← fire ? V_REST : (Vs < 0 ? 0 : Vs)
    - nxt_spk[idx] ← fire | frc_q[idx]
    - idx++; after idx = N−1 → DONE.
  - DONE → out_spikes ← nxt_spk; done = 1 for this cycle only → IDLE.
- Timing: step accepted at cycle t; RUN covers t+1..t+N; done and new out_spikes at t+N+1.
  - busy = 1 over t+1..t+N+1.
  - step is accepted again at t+N+2 at the earliest.
- out_spikes holds its value between done pulses; it is updated only in DONE.
- force_mask forces the spike bit only. The voltage update is unchanged: no reset to V_REST unless fire.
- step while busy: ignored, not queued.
- cfg_we:
  - in IDLE (cfg_ready=1), writes W[cfg_nrn][cfg_syn] at the clock edge;
  - while busy, dropped;
  - cfg_we and step in the same IDLE cycle: the write completes, and the timestep uses the new weight.
- v_rd_data reflects V after its clock-edge update; reads during RUN are permitted.
- Reset mid-RUN/DONE:
  - aborts immediately; no done pulse;
  - all state returns to reset values, including weights.
- Out-of-range cfg_nrn/cfg_syn/v_rd_addr (non-power-of-two N/S): write ignored; read returns 0.

Decomposition:
- Package lif_pkg:
  - state enum (IDLE, RUN, DONE);
  - width functions for VW and AW;
  - default threshold, rest, leak and gain constants.
- Sub-module lif_update: combinational single-neuron update.
  - Inputs: V, weight row, spike vector, force bit.
  - Outputs: V_next, spike.
  - The scheduler instantiates exactly one.

Test Plan (N=4, S=2, WW=4, defaults):
- Reset, then step with in_spikes=00, force_mask=0000 → done exactly at t+5; out_spikes=0000; every v_rd_data=5.
- W[0][0]=9, in_spikes=01, step from reset → V0 = 6+9−1 = 14 ≥ 14 → out_spikes[0]=1; V0=6. Other neurons 5, out bits 0.
- Leak clamp: from reset, 8 steps with no input → V sequence 5,4,3,2,1,0,0,0; never negative/wrapped; out_spikes always 0.
- force_mask=1000, no input → out_spikes=1000; V3=5, not V_REST. Next step with mask 0000 → out_spikes=0000.
- step and cfg_we pulsed during busy → no second timestep, weight unchanged (verified by a following step), single done pulse.
- Reset asserted at t+2 of a run → busy=0 and done never pulses; all V=6, out_spikes=0000, weights 0.
